// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-addressed data memory.
// Each accepted request takes three cycles: grant, memory access, response.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic [3:0]            p0_strb,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_err,

   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic [3:0]            p1_strb,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  p1_err,

   output logic                  mem_r,
   output logic                  mem_w,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_strb,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Two extra bits so that addr + 3 can never wrap past the top of the range.
   localparam int EXT_W = ADDR_WIDTH + 2;
   localparam logic [EXT_W-1:0] LAST_BYTE = EXT_W'(MEM_SIZE - 1);

   state_t state_reg;
   state_t state_next;

   logic                  last_gnt_reg;
   logic                  port_reg;
   logic                  we_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [3:0]            strb_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  err_reg;

   logic [1:0]            req_vec;
   logic [1:0]            we_vec;
   logic [ADDR_WIDTH-1:0] addr_arr  [2];
   logic [DATA_WIDTH-1:0] wdata_arr [2];
   logic [3:0]            strb_arr  [2];

   logic                  any_req;
   logic                  sel_port;
   logic                  addr_err;
   logic                  accept;

   logic [1:0]            gnt_vec;
   logic [1:0]            rvalid_vec;
   logic [1:0]            err_vec;
   logic [DATA_WIDTH-1:0] rdata_arr [2];
   logic                  resp_active;

   assign req_vec      = {p1_req, p0_req};
   assign we_vec       = {p1_we, p0_we};
   assign addr_arr[0]  = p0_addr;
   assign addr_arr[1]  = p1_addr;
   assign wdata_arr[0] = p0_wdata;
   assign wdata_arr[1] = p1_wdata;
   assign strb_arr[0]  = p0_strb;
   assign strb_arr[1]  = p1_strb;

   // Under contention the port not served last wins; a lone requester always wins.
   assign any_req  = |req_vec;
   assign sel_port = (&req_vec) ? ~last_gnt_reg : req_vec[1];
   assign accept   = (state_reg == IDLE) && any_req;

   assign addr_err = ({2'b00, addr_reg} + EXT_W'(3)) > LAST_BYTE;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (any_req) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt_reg <= 1'b1;
         port_reg     <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         strb_reg     <= '0;
         rdata_reg    <= '0;
         err_reg      <= 1'b0;
      end else begin
         if (accept) begin
            last_gnt_reg <= sel_port;
            port_reg     <= sel_port;
            we_reg       <= we_vec[sel_port];
            addr_reg     <= addr_arr[sel_port];
            wdata_reg    <= wdata_arr[sel_port];
            strb_reg     <= strb_arr[sel_port];
         end
         if (state_reg == ACCESS) begin
            rdata_reg <= (!we_reg && !addr_err) ? mem_rdata : '0;
            err_reg   <= addr_err;
         end
      end
   end

   // Output logic; reset forces every output low in the same cycle.
   always_comb begin
      gnt_vec     = 2'b00;
      resp_active = 1'b0;
      mem_r       = 1'b0;
      mem_w       = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_strb    = '0;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (any_req) gnt_vec[sel_port] = 1'b1;
            end
            ACCESS: begin
               mem_addr  = addr_reg;
               mem_wdata = wdata_reg;
               mem_strb  = strb_reg;
               mem_r     = !we_reg && !addr_err;
               mem_w     = we_reg && !addr_err;
            end
            RESP: begin
               resp_active = 1'b1;
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign rvalid_vec[gi] = resp_active && (port_reg == 1'(gi));
         assign err_vec[gi]    = rvalid_vec[gi] && err_reg;
         assign rdata_arr[gi]  = (rvalid_vec[gi] && !err_reg) ? rdata_reg : '0;
      end
   endgenerate

   assign p0_gnt    = gnt_vec[0];
   assign p0_rvalid = rvalid_vec[0];
   assign p0_err    = err_vec[0];
   assign p0_rdata  = rdata_arr[0];

   assign p1_gnt    = gnt_vec[1];
   assign p1_rvalid = rvalid_vec[1];
   assign p1_err    = err_vec[1];
   assign p1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian byte memory model that
// writes on the rising edge and reads combinationally.
module tb_dmem_arbiter;

   localparam int AW = 10;
   localparam int MS = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          fill;

   logic          p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
   logic [AW-1:0] p0_addr;
   logic [31:0]   p0_wdata, p0_rdata;
   logic [3:0]    p0_strb;

   logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
   logic [AW-1:0] p1_addr;
   logic [31:0]   p1_wdata, p1_rdata;
   logic [3:0]    p1_strb;

   logic          mem_r, mem_w;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic [3:0]    mem_strb;

   logic [7:0]    mem_bytes [0:MS-1];

   int            tests_run    = 0;
   int            tests_failed = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_SIZE(MS)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_strb(p0_strb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_strb(p1_strb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_strb(mem_strb), .mem_rdata(mem_rdata)
   );

   // Memory preloaded with byte i = i[7:0]; byte at addr+0 maps to bits [31:24].
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < MS; i++) mem_bytes[i] <= i[7:0];
      end else if (mem_w) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_strb[3-b] && (int'(mem_addr) + b < MS))
               mem_bytes[int'(mem_addr) + b] <= mem_wdata[31-8*b -: 8];
         end
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (int'(mem_addr) <= MS - 4)
         mem_rdata = {mem_bytes[mem_addr], mem_bytes[mem_addr + 10'd1],
                      mem_bytes[mem_addr + 10'd2], mem_bytes[mem_addr + 10'd3]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit p, input bit req, input bit we, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
      if (p) begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_strb = strb;
      end else begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_strb = strb;
      end
   endtask

   function automatic logic gnt_of(input bit p);
      return p ? p1_gnt : p0_gnt;
   endfunction

   function automatic logic rvalid_of(input bit p);
      return p ? p1_rvalid : p0_rvalid;
   endfunction

   function automatic logic err_of(input bit p);
      return p ? p1_err : p0_err;
   endfunction

   function automatic logic [31:0] rdata_of(input bit p);
      return p ? p1_rdata : p0_rdata;
   endfunction

   // One full transaction from IDLE: grant, access, response, with timing checks.
   task automatic run_txn(input string tag, input bit p, input bit we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input bit exp_err);
      logic [31:0] seen;
      drive(p, 1'b1, we, addr, wdata, strb);
      #2;
      check({tag, "/gnt"}, 32'(gnt_of(p)), 32'd1);
      check({tag, "/gnt_other"}, 32'(gnt_of(~p)), 32'd0);
      next_cycle;
      drive(p, 1'b0, 1'b0, '0, '0, '0);
      #2;
      check({tag, "/acc_gnt"}, 32'(gnt_of(p)), 32'd0);
      check({tag, "/mem_r"}, 32'(mem_r), 32'(!we && !exp_err));
      check({tag, "/mem_w"}, 32'(mem_w), 32'(we && !exp_err));
      if (!exp_err) check({tag, "/mem_addr"}, 32'(mem_addr), 32'(addr));
      if (!exp_err && we) begin
         check({tag, "/mem_wdata"}, mem_wdata, wdata);
         check({tag, "/mem_strb"}, 32'(mem_strb), 32'(strb));
      end
      next_cycle;
      #2;
      check({tag, "/rvalid"}, 32'(rvalid_of(p)), 32'd1);
      check({tag, "/rvalid_other"}, 32'(rvalid_of(~p)), 32'd0);
      check({tag, "/rdata"}, rdata_of(p), exp_rdata);
      check({tag, "/err"}, 32'(err_of(p)), 32'(exp_err));
      check({tag, "/rdata_other"}, rdata_of(~p), 32'd0);
      seen = rdata_of(p);
      $display("[TB] txn %s port=%0d we=%0d addr=0x%03h rdata=0x%08h err=%0d",
               tag, p, we, addr, seen, err_of(p));
      next_cycle;
   endtask

   initial begin
      rst  = 1'b1;
      fill = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      next_cycle;
      fill   = 1'b0;
      p0_req = 1'b1;
      p1_req = 1'b1;
      p1_we  = 1'b1;
      #2;
      check("rst/p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst/p1_gnt", 32'(p1_gnt), 32'd0);
      check("rst/rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
      check("rst/mem_rw", 32'({mem_r, mem_w}), 32'd0);
      check("rst/mem_addr", 32'(mem_addr), 32'd0);
      $display("[TB] txn reset held with both requests high");
      next_cycle;
      rst = 1'b0;

      // Contention from reset: p0 first, then alternate every 3 cycles.
      drive(1'b0, 1'b1, 1'b0, 10'h100, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 10'h104, '0, '0);
      for (int k = 0; k < 4; k++) begin
         bit exp_p;
         exp_p = k[0];
         #2;
         check($sformatf("cont%0d/p0_gnt", k), 32'(p0_gnt), 32'(!exp_p));
         check($sformatf("cont%0d/p1_gnt", k), 32'(p1_gnt), 32'(exp_p));
         next_cycle;
         #2;
         check($sformatf("cont%0d/acc_gnt", k), 32'({p1_gnt, p0_gnt}), 32'd0);
         check($sformatf("cont%0d/mem_addr", k), 32'(mem_addr), exp_p ? 32'h104 : 32'h100);
         next_cycle;
         #2;
         check($sformatf("cont%0d/p0_rvalid", k), 32'(p0_rvalid), 32'(!exp_p));
         check($sformatf("cont%0d/p1_rvalid", k), 32'(p1_rvalid), 32'(exp_p));
         check($sformatf("cont%0d/rdata", k), rdata_of(exp_p),
               exp_p ? 32'h04050607 : 32'h00010203);
         $display("[TB] txn contention round %0d granted port %0d", k, exp_p);
         next_cycle;
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      next_cycle;

      run_txn("wr010",        1'b0, 1'b1, 10'h010, 32'hCAFEF00D, 4'hF,    32'h0,        1'b0);
      run_txn("rd010",        1'b0, 1'b0, 10'h010, 32'h0,        4'h0,    32'hCAFEF00D, 1'b0);
      run_txn("wr020_full",   1'b1, 1'b1, 10'h020, 32'h11223344, 4'hF,    32'h0,        1'b0);
      run_txn("wr020_part",   1'b1, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0011, 32'h0,        1'b0);
      run_txn("rd020",        1'b1, 1'b0, 10'h020, 32'h0,        4'hF,    32'h1122CCDD, 1'b0);
      run_txn("wr020_nostrb", 1'b0, 1'b1, 10'h020, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0);
      run_txn("rd020_again",  1'b0, 1'b0, 10'h020, 32'h0,        4'h0,    32'h1122CCDD, 1'b0);
      run_txn("rd_oob",       1'b0, 1'b0, 10'd1022, 32'h0,       4'hF,    32'h0,        1'b1);
      run_txn("rd_last",      1'b0, 1'b0, 10'd1020, 32'h0,       4'hF,    32'hFCFDFEFF, 1'b0);
      run_txn("wr_oob",       1'b1, 1'b1, 10'd1021, 32'h12345678, 4'hF,   32'h0,        1'b1);
      run_txn("rd_last_2",    1'b1, 1'b0, 10'd1020, 32'h0,       4'hF,    32'hFCFDFEFF, 1'b0);

      // Reset arriving in the ACCESS cycle of a write.
      run_txn("wr040",        1'b0, 1'b1, 10'h040, 32'h01020304, 4'hF,    32'h0,        1'b0);
      drive(1'b0, 1'b1, 1'b1, 10'h040, 32'hDEADBEEF, 4'hF);
      #2;
      check("rstacc/gnt", 32'(p0_gnt), 32'd1);
      next_cycle;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      rst = 1'b1;
      #2;
      check("rstacc/mem_w", 32'(mem_w), 32'd0);
      check("rstacc/mem_r", 32'(mem_r), 32'd0);
      next_cycle;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         check($sformatf("rstacc/rvalid%0d", k), 32'({p1_rvalid, p0_rvalid}), 32'd0);
         check($sformatf("rstacc/mem_w%0d", k), 32'(mem_w), 32'd0);
         next_cycle;
      end
      $display("[TB] txn reset during write access to 0x040");
      run_txn("rd040",        1'b0, 1'b0, 10'h040, 32'h0,        4'h0,    32'h01020304, 1'b0);

      // p1 pulses its request only while p0 occupies ACCESS.
      drive(1'b0, 1'b1, 1'b0, 10'h010, '0, '0);
      #2;
      check("wd/p0_gnt", 32'(p0_gnt), 32'd1);
      next_cycle;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b1, 1'b1, 10'h080, 32'h55555555, 4'hF);
      #2;
      check("wd/acc_p1_gnt", 32'(p1_gnt), 32'd0);
      check("wd/acc_mem_rw", 32'({mem_r, mem_w}), 32'b10);
      next_cycle;
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      #2;
      check("wd/resp_p1_gnt", 32'(p1_gnt), 32'd0);
      check("wd/p0_rdata", p0_rdata, 32'hCAFEF00D);
      for (int k = 0; k < 3; k++) begin
         next_cycle;
         #2;
         check($sformatf("wd/idle%0d_mem_rw", k), 32'({mem_r, mem_w}), 32'd0);
         check($sformatf("wd/idle%0d_p1", k), 32'({p1_gnt, p1_rvalid}), 32'd0);
      end
      $display("[TB] txn withdrawn p1 request during p0 access");
      next_cycle;
      run_txn("rd080",        1'b1, 1'b0, 10'h080, 32'h0,        4'h0,    32'h80818283, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
